// File: rtl/video_tape_encoder_pkg.sv
// Shared types and helpers for the video tape encoder (package video_tape_pkg).
// The CRC helper is only referenced when TAPE_ENC_CRC_EN is defined.
package video_tape_pkg;

   localparam logic [7:0] SYNC_LEVEL = 8'd0;
   localparam logic [7:0] CRC_POLY   = 8'h07;

   typedef enum logic [1:0] {
      VSYNC,
      BLANK,
      ACTIVE_DATA,
      ACTIVE_IDLE
   } line_class_e;

   // Evenly spaced grey levels between black and white, floor division.
   function automatic logic [7:0] sym_to_level(input logic [3:0] sym, input int bits,
                                               input int black, input int white);
      int step;
      step = (white - black) / ((1 << bits) - 1);
      return 8'(black + int'(sym) * step);
   endfunction

   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/video_tape_encoder_line_buffer.sv
// Ping-pong line buffer: one bank fills from the stream while the other is read by symbol index.
// With TAPE_ENC_CRC_EN defined the last slot of each fill holds a CRC-8 of the payload.
module tape_line_buffer
   import video_tape_pkg::*;
#(
   parameter int BYTES = 80,
   parameter int BPS   = 2,
   parameter int SYMS  = 320
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_wr_en,
   input  logic [7:0]              i_wr_data,
   input  logic                    i_swap,
   input  logic [$clog2(SYMS)-1:0] i_rd_sym,
   output logic                    o_full,
   output logic                    o_wr_ready,
   output logic [BPS-1:0]          o_rd_sym
);

   localparam int PW      = $clog2(BYTES + 1);
   localparam int WA      = $clog2(BYTES);
   localparam int SPB_LOG = $clog2(8 / BPS);

   logic [7:0]         r_mem [2][BYTES];
   logic               r_back;
   logic [PW-1:0]      r_wptr;
   logic               r_full;
   logic               w_we;
   logic [7:0]         w_wdata;
   logic [WA-1:0]      w_rd_byte;
   logic [SPB_LOG-1:0] w_slot;
   logic [2:0]         w_shift;
   logic [7:0]         w_rd_word;

`ifdef TAPE_ENC_CRC_EN
   logic [7:0] r_crc;
   logic       w_last;
   logic       w_crc_wr;

   // The final slot is reserved: the stream is held off for one cycle while the CRC lands there.
   assign w_last     = (r_wptr == PW'(BYTES - 1));
   assign o_wr_ready = !r_full && !w_last;
   assign w_crc_wr   = !r_full && w_last;
   assign w_we       = (i_wr_en && o_wr_ready) || w_crc_wr;
   assign w_wdata    = w_crc_wr ? r_crc : i_wr_data;
`else
   assign o_wr_ready = !r_full;
   assign w_we       = i_wr_en && o_wr_ready;
   assign w_wdata    = i_wr_data;
`endif

   assign o_full = r_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_back <= 1'b0;
         r_wptr <= '0;
         r_full <= 1'b0;
`ifdef TAPE_ENC_CRC_EN
         r_crc  <= 8'h00;
`endif
      end else if (i_swap) begin
         r_back <= ~r_back;
         r_wptr <= '0;
         r_full <= 1'b0;
`ifdef TAPE_ENC_CRC_EN
         r_crc  <= 8'h00;
`endif
      end else if (w_we) begin
         r_wptr <= r_wptr + PW'(1);
         if (r_wptr == PW'(BYTES - 1)) begin
            r_full <= 1'b1;
         end
`ifdef TAPE_ENC_CRC_EN
         if (!w_crc_wr) begin
            r_crc <= crc8_update(r_crc, i_wr_data);
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (w_we && !i_swap) begin
         r_mem[r_back][r_wptr[WA-1:0]] <= w_wdata;
      end
   end

   // Symbols are taken MSB-first within a byte.
   assign w_rd_byte = WA'(i_rd_sym >> SPB_LOG);
   assign w_slot    = i_rd_sym[SPB_LOG-1:0];
   assign w_shift   = 3'(8 - BPS * (int'(w_slot) + 1));
   assign w_rd_word = r_mem[~r_back][w_rd_byte];
   assign o_rd_sym  = BPS'(w_rd_word >> w_shift);

endmodule

// File: rtl/video_tape_encoder.sv
// NTSC-timed line encoder: packs a byte stream into grey-level symbols with its own sync.
// Define TAPE_ENC_CRC_EN to replace the last byte of each line with a CRC-8.
module video_tape_encoder
   import video_tape_pkg::*;
#(
   parameter int BITS_PER_SYM    = 2,
   parameter int SYMS_PER_LINE   = 320,
   parameter int CLKS_PER_SYM    = 2,
   parameter int HDR_SYMS        = 16,
   parameter int LINE_CLKS       = 858,
   parameter int SYNC_CLKS       = 63,
   parameter int ACTIVE_START    = 122,
   parameter int LINES_PER_FIELD = 262,
   parameter int VSYNC_LINES     = 3,
   parameter int BLANK_LINES     = 21,
   parameter int BLACK_LEVEL     = 72,
   parameter int WHITE_LEVEL     = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] video_out,
   output logic       sync,
   output logic       line_start,
   output logic       field_start,
   output logic       idle_line
);

   localparam int BYTES_PER_LINE = SYMS_PER_LINE * BITS_PER_SYM / 8;
   localparam int HW             = $clog2(LINE_CLKS);
   localparam int VW             = $clog2(LINES_PER_FIELD);
   localparam int SW             = $clog2(SYMS_PER_LINE);
   localparam int WIN_CLKS       = (HDR_SYMS + SYMS_PER_LINE) * CLKS_PER_SYM;
   localparam logic [BITS_PER_SYM-1:0] SYM_MAX = '1;

   logic                    r_run;
   logic [HW-1:0]           r_h;
   logic [VW-1:0]           r_v;
   line_class_e             r_class;
   logic [7:0]              r_video;
   logic                    r_sync;

   logic                    w_h0;
   logic                    w_active_v;
   logic                    w_full;
   logic                    w_wr_ready;
   logic                    w_swap;
   logic                    w_in_win;
   logic [HW-1:0]           w_off;
   logic [HW-1:0]           w_sym_idx;
   logic [SW-1:0]           w_data_idx;
   logic [BITS_PER_SYM-1:0] w_buf_sym;
   logic [BITS_PER_SYM-1:0] w_sym;
   logic [7:0]              w_video_nxt;
   logic                    w_sync_nxt;

   // Handshake: a byte moves on any clock with in_valid && in_ready; in_ready never looks at in_valid.
   // r_run holds the counters at h=0 for the first clock after reset so line 0 gets its pulses.
   assign w_h0        = r_run && (r_h == '0);
   assign w_active_v  = (r_v >= VW'(BLANK_LINES));
   assign w_swap      = w_h0 && w_active_v && w_full;
   assign line_start  = w_h0;
   assign field_start = w_h0 && (r_v == '0);
   assign idle_line   = w_h0 && w_active_v && !w_full;
   assign in_ready    = r_run && w_wr_ready;

   assign w_off      = r_h - HW'(ACTIVE_START);
   assign w_in_win   = (r_h >= HW'(ACTIVE_START)) && (w_off < HW'(WIN_CLKS));
   assign w_sym_idx  = w_off / HW'(CLKS_PER_SYM);
   assign w_data_idx = SW'(w_sym_idx - HW'(HDR_SYMS));

   tape_line_buffer #(
      .BYTES (BYTES_PER_LINE),
      .BPS   (BITS_PER_SYM),
      .SYMS  (SYMS_PER_LINE)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst),
      .i_wr_en    (in_valid && r_run),
      .i_wr_data  (in_data),
      .i_swap     (w_swap),
      .i_rd_sym   (w_data_idx),
      .o_full     (w_full),
      .o_wr_ready (w_wr_ready),
      .o_rd_sym   (w_buf_sym)
   );

   always_comb begin
      w_sym = '0;
      if (r_class == ACTIVE_DATA) begin
         if (w_sym_idx < HW'(HDR_SYMS)) begin
            w_sym = w_sym_idx[0] ? '0 : SYM_MAX;
         end else begin
            w_sym = w_buf_sym;
         end
      end

      w_sync_nxt  = 1'b1;
      w_video_nxt = 8'(BLACK_LEVEL);
      if (r_v < VW'(VSYNC_LINES)) begin
         if (r_h < HW'(LINE_CLKS - SYNC_CLKS)) begin
            w_sync_nxt  = 1'b0;
            w_video_nxt = SYNC_LEVEL;
         end
      end else if (r_h < HW'(SYNC_CLKS)) begin
         w_sync_nxt  = 1'b0;
         w_video_nxt = SYNC_LEVEL;
      end else if (w_active_v && w_in_win) begin
         w_video_nxt = sym_to_level(4'(w_sym), BITS_PER_SYM, BLACK_LEVEL, WHITE_LEVEL);
      end
   end

   // Line class is latched at h==0; the stale value on that one clock only meets the sync region.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run   <= 1'b0;
         r_h     <= '0;
         r_v     <= '0;
         r_class <= VSYNC;
         r_video <= 8'(BLACK_LEVEL);
         r_sync  <= 1'b1;
      end else begin
         r_run <= 1'b1;
         if (r_run) begin
            if (r_h == HW'(LINE_CLKS - 1)) begin
               r_h <= '0;
               r_v <= (r_v == VW'(LINES_PER_FIELD - 1)) ? '0 : r_v + VW'(1);
            end else begin
               r_h <= r_h + HW'(1);
            end

            if (r_h == '0) begin
               if (r_v < VW'(VSYNC_LINES)) begin
                  r_class <= VSYNC;
               end else if (!w_active_v) begin
                  r_class <= BLANK;
               end else if (w_full) begin
                  r_class <= ACTIVE_DATA;
               end else begin
                  r_class <= ACTIVE_IDLE;
               end
            end

            r_video <= w_video_nxt;
            r_sync  <= w_sync_nxt;
         end
      end
   end

   assign video_out = r_video;
   assign sync      = r_sync;

endmodule

// File: tb/tb_video_tape_encoder.sv
// Bench for video_tape_encoder on a shrunken raster; a line-level model predicts every output each clock.
// Follows TAPE_ENC_CRC_EN when the macro is defined for the build.
module tb_video_tape_encoder;

   localparam int BPS   = 2;
   localparam int SYMS  = 16;
   localparam int CPS   = 2;
   localparam int HDR   = 4;
   localparam int LCLK  = 80;
   localparam int SCLK  = 6;
   localparam int AS    = 12;
   localparam int LPF   = 20;
   localparam int VSL   = 3;
   localparam int BL    = 5;
   localparam int BLACK = 72;
   localparam int WHITE = 255;
   localparam int BYTES = SYMS * BPS / 8;
`ifdef TAPE_ENC_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] video_out;
   logic       sync;
   logic       line_start;
   logic       field_start;
   logic       idle_line;

   always #5 clk = ~clk;

   video_tape_encoder #(
      .BITS_PER_SYM    (BPS),
      .SYMS_PER_LINE   (SYMS),
      .CLKS_PER_SYM    (CPS),
      .HDR_SYMS        (HDR),
      .LINE_CLKS       (LCLK),
      .SYNC_CLKS       (SCLK),
      .ACTIVE_START    (AS),
      .LINES_PER_FIELD (LPF),
      .VSYNC_LINES     (VSL),
      .BLANK_LINES     (BL),
      .BLACK_LEVEL     (BLACK),
      .WHITE_LEVEL     (WHITE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .video_out   (video_out),
      .sync        (sync),
      .line_start  (line_start),
      .field_start (field_start),
      .idle_line   (idle_line)
   );

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] front [BYTES];
   bit         line_data;
   int         m_h;
   int         m_v;
   logic [7:0] exp_video;
   logic       exp_sync;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d (h=%0d v=%0d)", tag, obs, exp, m_h, m_v);
      end
   endtask

   function automatic logic [7:0] crc_of_q();
      logic [7:0] c = 8'h00;
      foreach (exp_q[i]) begin
         c = c ^ exp_q[i];
         for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   function automatic int level_of(input int s);
      return BLACK + s * ((WHITE - BLACK) / ((1 << BPS) - 1));
   endfunction

   // {sync, video} the raster rules give for position (h, v) of the current line.
   function automatic logic [8:0] decode(input int h, input int v);
      int sym;
      int bitpos;
      int s;
      if (v < VSL) return (h < LCLK - SCLK) ? 9'h000 : {1'b1, 8'(BLACK)};
      if (h < SCLK) return 9'h000;
      if (v < BL || h < AS || h >= AS + (HDR + SYMS) * CPS) return {1'b1, 8'(BLACK)};
      sym = (h - AS) / CPS;
      if (!line_data) s = 0;
      else if (sym < HDR) s = (sym % 2 == 0) ? (1 << BPS) - 1 : 0;
      else begin
         bitpos = (sym - HDR) * BPS;
         s = int'(front[bitpos / 8] >> (8 - BPS - bitpos % 8)) & ((1 << BPS) - 1);
      end
      return {1'b1, 8'(level_of(s))};
   endfunction

   task automatic start_model();
      exp_q.delete();
      line_data = 1'b0;
      m_h = 0;
      m_v = 0;
      exp_video = 8'(BLACK);
      exp_sync = 1'b1;
   endtask

   task automatic reset_checks();
      chk("rst_video", video_out, BLACK);
      chk("rst_sync", sync, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_line_start", line_start, 0);
      chk("rst_field_start", field_start, 0);
      chk("rst_idle_line", idle_line, 0);
   endtask

   // One clock: check the visible state, advance the model, drive this cycle's input.
   task automatic cycle(input int pct, output bit acc);
      bit         full;
      bit         ready_m;
      logic [8:0] dec;
      full    = (exp_q.size() == BYTES);
      ready_m = CRC_ON ? (exp_q.size() < BYTES - 1) : (exp_q.size() < BYTES);
      chk("in_ready", in_ready, ready_m);
      chk("line_start", line_start, m_h == 0);
      chk("field_start", field_start, m_h == 0 && m_v == 0);
      chk("idle_line", idle_line, m_h == 0 && m_v >= BL && !full);
      chk("video_out", video_out, exp_video);
      chk("sync", sync, exp_sync);

      if (m_h == 0) begin
         line_data = 1'b0;
         if (m_v >= BL && full) begin
            for (int i = 0; i < BYTES; i++) front[i] = exp_q.pop_front();
            line_data = 1'b1;
         end
      end
      dec = decode(m_h, m_v);
      exp_video = dec[7:0];
      exp_sync = dec[8];

      in_valid = ($urandom_range(99) < pct);
      in_data = 8'($urandom);
      acc = in_valid && ready_m;
      if (acc) exp_q.push_back(in_data);
      if (CRC_ON && !full && exp_q.size() == BYTES - 1 && !ready_m) exp_q.push_back(crc_of_q());

      m_h++;
      if (m_h == LCLK) begin
         m_h = 0;
         m_v = (m_v + 1) % LPF;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n, input int pct);
      bit acc;
      for (int i = 0; i < n; i++) cycle(pct, acc);
   endtask

   task automatic feed(input int k);
      bit acc;
      int got = 0;
      int budget = 4 * LPF * LCLK;
      while (got < k && budget > 0) begin
         cycle(100, acc);
         if (acc) got++;
         budget--;
      end
   endtask

   initial begin
      bit acc;
      int budget;
      repeat (3) begin
         @(posedge clk);
         #1;
         reset_checks();
      end
      start_model();
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_cycles(LPF * LCLK * 3 / 2, 0);
      run_cycles(LPF * LCLK * 2, 50);
      run_cycles(LPF * LCLK, 100);

      // Top up and let the line go out, then split the next line's bytes around a stall.
      feed((CRC_ON ? BYTES - 1 : BYTES) - exp_q.size());
      budget = 2 * LPF * LCLK;
      while (exp_q.size() != 0 && budget > 0) begin
         cycle(0, acc);
         budget--;
      end
      feed(BYTES / 2);
      run_cycles(6 * LCLK, 0);
      feed((CRC_ON ? BYTES - 1 : BYTES) - BYTES / 2);
      run_cycles(6 * LCLK, 0);

      run_cycles(LPF * LCLK + 37, 60);
      in_valid = 1'b0;
      rst = 1'b0;
      #2;
      reset_checks();
      @(posedge clk);
      #1;
      reset_checks();
      start_model();
      rst = 1'b1;
      @(posedge clk);
      #1;
      run_cycles(LPF * LCLK * 2, 30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/video_tape_encoder.md
# video_tape_encoder

Parametrised NTSC-timed line encoder for the datatape path. It takes a byte stream from the Ethernet side and packs it into multilevel grey symbols on active video lines. It generates its own horizontal and vertical sync and drives the composite DAC (VGA_R/G/B plus VGA_SYNC_N) in place of the fixed-pattern video generator. It runs on the NTSC pixel clock, and clock-domain crossing of the input stream is done upstream.

## Interface
- BITS_PER_SYM, 2, bits per symbol; legal values 1, 2, 4 (symbols never straddle bytes)
- SYMS_PER_LINE, 320, data symbols per active line; SYMS_PER_LINE*BITS_PER_SYM must be a multiple of 8
- CLKS_PER_SYM, 2, clocks each symbol is held
- HDR_SYMS, 16, header symbols ahead of data on each active line
- LINE_CLKS, 858, clocks per line
- SYNC_CLKS, 63, hsync width in clocks
- ACTIVE_START, 122, h count of first header symbol; requires ACTIVE_START+(HDR_SYMS+SYMS_PER_LINE)*CLKS_PER_SYM ≤ LINE_CLKS
- LINES_PER_FIELD, 262; VSYNC_LINES, 3; BLANK_LINES, 21 (lines 0..BLANK_LINES-1 carry no data)
- BLACK_LEVEL, 72; WHITE_LEVEL, 255, DAC codes
- clk  in  1  NTSC pixel clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- video_out  out  8  DAC code
- sync  out  1  composite sync, active-low
- line_start  out  1  one-cycle pulse at h==0
- field_start  out  1  one-cycle pulse at h==0, line 0
- idle_line  out  1  one-cycle pulse when an active line is sent without data

## Operation
- BYTES_PER_LINE = SYMS_PER_LINE*BITS_PER_SYM/8 (80 at defaults).
- Counters: h counts 0..LINE_CLKS-1 and wraps; v increments on h wrap and counts 0..LINES_PER_FIELD-1. Scan is progressive, with no interlace.
- Line classes:
  - v < VSYNC_LINES: sync=0 and video=0 for h < LINE_CLKS-SYNC_CLKS; otherwise sync=1, video=BLACK_LEVEL.
  - Other lines: sync=0 and video=0 for h < SYNC_CLKS; otherwise sync=1, video=BLACK_LEVEL outside the symbol window.
- Symbol window (only lines with v ≥ BLANK_LINES): HDR_SYMS header symbols, then SYMS_PER_LINE data symbols, each held CLKS_PER_SYM clocks.
- Level mapping: symbol s maps to BLACK_LEVEL + s*((WHITE_LEVEL-BLACK_LEVEL)/(2^BITS_PER_SYM-1)), with integer floor. Defaults give 72/133/194/255.
- Header on a data line: alternating max symbol and 0, starting with max. Header on an idle line: all symbol 0, and all data symbols are 0.
- Bit packing: data symbols are taken MSB-first within each byte, bytes in arrival order.
- Buffering: ping-pong line buffer of 2×BYTES_PER_LINE bytes, one front and one back.
  - The back buffer fills from the stream. in_ready=1 while the back buffer is not full.
  - Swap decision at h==0 of each line with v ≥ BLANK_LINES:
    - Back buffer full: swap buffers, send a data line, empty the new back buffer.
    - Back buffer not full: send an idle line, pulse idle_line, and keep the partial fill (never discarded).
  - A byte accepted on the swap cycle goes to the new back buffer.
- Reset mid-line: counters go to 0 and both buffers empty. Output restarts at line 0 after reset release.

## Timing
- Reset values: video_out=BLACK_LEVEL, sync=1, in_ready=0, line_start=0, field_start=0, idle_line=0, h=0, v=0.
- in_ready goes to 1 on the first clk after reset release.
- video_out and sync are registered, one clock after the h/v state they decode. All outputs change on posedge clk.
- line_start and field_start are asserted in the cycle with h==0 (counter state). idle_line is asserted on the same cycle.
- in_ready falls in the cycle after the byte that fills the back buffer is accepted. It rises the cycle after a swap.
- Throughput: one byte per clock maximum.

## Configuration
- TAPE_ENC_CRC_EN defined:
  - The last byte of each line is a CRC-8 (poly 0x07, init 0x00, MSB-first) over the BYTES_PER_LINE-1 payload bytes.
  - The CRC is computed as bytes are written. in_ready is held 0 for one cycle while the CRC byte is written to the final slot.
  - Idle lines carry all-zero symbols, including the CRC position.
- TAPE_ENC_CRC_EN undefined: all BYTES_PER_LINE bytes are payload and there is no CRC logic.

## Structure
- Package video_tape_pkg holds:
  - sync level constant (0);
  - CRC_POLY (8'h07);
  - symbol-to-level function;
  - line-class enum: VSYNC, BLANK, ACTIVE_DATA, ACTIVE_IDLE.
- Sub-module tape_line_buffer: dual-bank byte RAM with write pointer, full flag and swap input, plus a read port addressed by symbol index.

## Test plan
- Reset release with no input: every line with v ≥ 21 is idle; video_out is 72 across the symbol window; one idle_line pulse per active line; sync is low exactly 63 clocks per line.
- Field timing: field_start pulses every 262×858 clocks; lines 0–2 have sync low for 795 clocks.
- Stream 80 bytes of 0x1B before line 21 (CRC off): header is 255,72 alternating; data level sequence 72,133,194,255 repeats, each level held 2 clocks, first data symbol at h=154.
- Stall after 40 bytes: the next active line is idle and idle_line pulses; 40 more bytes then produce a data line whose bytes appear in original order.
- Backpressure: continuous in_valid; in_ready drops after byte 80 and rises one cycle after the next swap; no byte lost or duplicated across 10 lines.
- TAPE_ENC_CRC_EN on: 79 bytes 0x00..0x4E; the final 4 symbols encode the CRC-8 of those bytes; in_ready is low for exactly one extra cycle per line.
